// File: rtl/aes_key_expander_seq.sv
// Iterative AES-128/192/256 key-schedule engine, one schedule word per clock, with registered round-key read port.
// Optional clear-on-request is compiled in with AES_KEY_ZEROIZE_EN.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = x;
    for (int unsigned k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // Multiplicative inverse as a^254 by square-and-multiply; 0 maps to 0.
  always_comb begin
    inv = 8'h01;
    for (int unsigned k = 0; k < 8; k++) begin
      inv = gmul(inv, inv);
      if (k != 7) inv = gmul(inv, a);
    end
    c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander_seq #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
`ifdef AES_KEY_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int AW = $clog2(NW);
  localparam int PW = $clog2(NK);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
`ifdef AES_KEY_ZEROIZE_EN
    ,
    ZERO
`endif
  } state_t;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [PW-1:0]     pos;
  logic [7:0]        rcon;
  logic [32*NK-1:0]  key_q;
  logic [31:0]       mem [NW];

  logic [31:0] prev, far, sub_in, sub_out, t, next_word;
  logic [5:0]  rd_base;

  generate
    if (NK < 8) begin : g_unused_key
      logic unused_key_bits;
      assign unused_key_bits = ^key_in[255-32*NK:0];
    end
  endgenerate

  assign prev    = mem[idx - AW'(1)];
  assign far     = mem[idx - AW'(NK)];
  assign rd_base = {rd_round, 2'b00};

  // pos tracks i mod NK so no divider is needed.
  always_comb begin
    sub_in = (pos == '0) ? {prev[23:0], prev[31:24]} : prev;
    t      = prev;
    if (pos == '0)
      t = sub_out ^ {rcon, 24'h0};
    else if (NK == 8 && pos == PW'(4))
      t = sub_out;
    next_word = far ^ t;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (.a(sub_in[8*g +: 8]), .c(sub_out[8*g +: 8]));
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int unsigned k = 0; k < NK; k++)
        mem[k] <= key_q[32*NK-1-32*k -: 32];
    end else if (state == EXPAND) begin
      mem[idx] <= next_word;
    end
`ifdef AES_KEY_ZEROIZE_EN
    else if (state == ZERO && !zeroize) begin
      mem[idx] <= '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      rd_key     <= '0;
      rcon       <= 8'h01;
      idx        <= '0;
      pos        <= '0;
      key_q      <= '0;
    end else begin
      done   <= 1'b0;
      rd_key <= (rd_round <= 4'(NR))
                ? {mem[rd_base], mem[rd_base + 6'd1], mem[rd_base + 6'd2], mem[rd_base + 6'd3]}
                : '0;
`ifdef AES_KEY_ZEROIZE_EN
      if (zeroize) begin
        state      <= ZERO;
        idx        <= '0;
        keys_ready <= 1'b0;
        busy       <= 1'b1;
        key_ready  <= 1'b0;
      end else
`endif
      begin
        case (state)
          IDLE, DONE: begin
            if (key_valid) begin
              key_q      <= key_in[255 -: 32*NK];
              state      <= LOAD;
              busy       <= 1'b1;
              key_ready  <= 1'b0;
              keys_ready <= 1'b0;
            end
          end
          LOAD: begin
            state <= EXPAND;
            idx   <= AW'(NK);
            pos   <= '0;
            rcon  <= 8'h01;
          end
          EXPAND: begin
            idx <= idx + AW'(1);
            pos <= (pos == PW'(NK - 1)) ? '0 : pos + PW'(1);
            if (pos == '0)
              rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (idx == AW'(NW - 1)) begin
              state      <= DONE;
              done       <= 1'b1;
              keys_ready <= 1'b1;
              busy       <= 1'b0;
              key_ready  <= 1'b1;
            end
          end
`ifdef AES_KEY_ZEROIZE_EN
          ZERO: begin
            idx <= idx + AW'(1);
            if (idx == AW'(NW - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              key_ready <= 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
